// File: rtl/lfsr_bist_sequencer.sv
// BIST sequencer for the 8-bit PRBS generator / checker_lfsr pair.
// Drives soft reset, valid and corruption, measures lock/unlock latency,
// and reports pass/fail with a failure code. All outputs are registered.
module lfsr_bist_sequencer #(
  parameter int unsigned CNT_W          = 8,
  parameter int unsigned LOCK_TIMEOUT   = 32,
  parameter int unsigned UNLOCK_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [CNT_W-1:0] i_valid_len,
  input  logic             i_lock,
  output logic             o_soft_reset,
  output logic             o_valid,
  output logic             o_corrupt,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic [2:0]       o_fail_code,
  output logic [CNT_W-1:0] o_lock_lat,
  output logic [CNT_W-1:0] o_unlock_lat
);

  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] LOCK_TO    = CNT_W'(LOCK_TIMEOUT);
  localparam logic [CNT_W-1:0] UNLOCK_TO  = CNT_W'(UNLOCK_TIMEOUT);

  localparam logic [2:0] FAIL_NONE     = 3'd0;
  localparam logic [2:0] FAIL_LOCK_TO  = 3'd1;
  localparam logic [2:0] FAIL_SPURIOUS = 3'd2;
  localparam logic [2:0] FAIL_UNLK_TO  = 3'd3;
  localparam logic [2:0] FAIL_RELK_TO  = 3'd4;
  localparam logic [2:0] FAIL_ABORT    = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SRST   = 3'd1,
    S_SYNC   = 3'd2,
    S_HOLD   = 3'd3,
    S_INJECT = 3'd4,
    S_RELOCK = 3'd5,
    S_DONE   = 3'd6
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [2:0]       fail_q, fail_d;
  logic [CNT_W-1:0] lock_lat_q, lock_lat_d;
  logic [CNT_W-1:0] unlock_lat_q, unlock_lat_d;
  logic             pass_q, pass_d;
  logic [2:0]       code_q, code_d;
  logic             soft_reset_q, valid_q, corrupt_q, busy_q, done_q;
  logic             abort_c;

  // Abort applies to every active state except the final DONE cycle
  assign abort_c = i_abort && (state_q != S_IDLE) && (state_q != S_DONE);

  // Next-state, result capture and state-cycle counter
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    fail_d       = fail_q;
    lock_lat_d   = lock_lat_q;
    unlock_lat_d = unlock_lat_q;
    pass_d       = pass_q;
    code_d       = code_q;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d      = S_SRST;
          len_d        = i_valid_len;
          fail_d       = FAIL_NONE;
          lock_lat_d   = '0;
          unlock_lat_d = '0;
          pass_d       = 1'b0;
          code_d       = FAIL_NONE;
        end
      end
      S_SRST: begin
        state_d = S_SYNC;
      end
      S_SYNC: begin
        if (i_lock) begin
          lock_lat_d = cnt_q;
          state_d    = S_HOLD;
        end else if (cnt_q >= LOCK_TO) begin
          fail_d  = FAIL_LOCK_TO;
          state_d = S_DONE;
        end
      end
      S_HOLD: begin
        if (!i_lock) begin
          fail_d  = FAIL_SPURIOUS;
          state_d = S_DONE;
        end else if (cnt_q >= len_q) begin
          state_d = S_INJECT;
        end
      end
      S_INJECT: begin
        if (!i_lock) begin
          unlock_lat_d = cnt_q;
          state_d      = S_RELOCK;
        end else if (cnt_q >= UNLOCK_TO) begin
          fail_d  = FAIL_UNLK_TO;
          state_d = S_DONE;
        end
      end
      S_RELOCK: begin
        if (i_lock) begin
          fail_d  = FAIL_NONE;
          state_d = S_DONE;
        end else if (cnt_q >= LOCK_TO) begin
          fail_d  = FAIL_RELK_TO;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides any lock/timeout decision made above
    if (abort_c) begin
      fail_d  = FAIL_ABORT;
      state_d = S_DONE;
    end

    // Results are published on entry to DONE
    if (state_d == S_DONE && state_q != S_DONE) begin
      pass_d = (fail_d == FAIL_NONE);
      code_d = fail_d;
    end

    // Counter restarts at 1 on every state change and saturates
    if (state_d != state_q) begin
      cnt_d = CNT_ONE;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // State, bookkeeping and Moore outputs decoded from the next state
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      len_q        <= '0;
      fail_q       <= FAIL_NONE;
      lock_lat_q   <= '0;
      unlock_lat_q <= '0;
      pass_q       <= 1'b0;
      code_q       <= FAIL_NONE;
      soft_reset_q <= 1'b0;
      valid_q      <= 1'b0;
      corrupt_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      fail_q       <= fail_d;
      lock_lat_q   <= lock_lat_d;
      unlock_lat_q <= unlock_lat_d;
      pass_q       <= pass_d;
      code_q       <= code_d;
      soft_reset_q <= (state_d == S_SRST);
      valid_q      <= (state_d == S_SYNC) || (state_d == S_HOLD) ||
                      (state_d == S_INJECT) || (state_d == S_RELOCK);
      corrupt_q    <= (state_d == S_INJECT);
      busy_q       <= (state_d != S_IDLE);
      done_q       <= (state_d == S_DONE);
    end
  end

  assign o_soft_reset = soft_reset_q;
  assign o_valid      = valid_q;
  assign o_corrupt    = corrupt_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_pass       = pass_q;
  assign o_fail_code  = code_q;
  assign o_lock_lat   = lock_lat_q;
  assign o_unlock_lat = unlock_lat_q;

endmodule

// File: tb/tb_lfsr_bist_sequencer.sv
// Bench for lfsr_bist_sequencer: a behavioural checker model drives i_lock,
// runs are described by a table of expected results, plus reset sequences.
module tb_lfsr_bist_sequencer;

  localparam int unsigned CNT_W = 8;

  logic             clk = 1'b0;
  logic             i_rst = 1'b1;
  logic             i_start = 1'b0;
  logic             i_abort = 1'b0;
  logic [CNT_W-1:0] i_valid_len = '0;
  logic             i_lock = 1'b0;
  logic             o_soft_reset, o_valid, o_corrupt, o_busy, o_done, o_pass;
  logic [2:0]       o_fail_code;
  logic [CNT_W-1:0] o_lock_lat, o_unlock_lat;

  int errors = 0;
  int checks = 0;

  lfsr_bist_sequencer #(.CNT_W(CNT_W), .LOCK_TIMEOUT(32), .UNLOCK_TIMEOUT(16)) dut (
    .clk          (clk),
    .i_rst        (i_rst),
    .i_start      (i_start),
    .i_abort      (i_abort),
    .i_valid_len  (i_valid_len),
    .i_lock       (i_lock),
    .o_soft_reset (o_soft_reset),
    .o_valid      (o_valid),
    .o_corrupt    (o_corrupt),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_pass       (o_pass),
    .o_fail_code  (o_fail_code),
    .o_lock_lat   (o_lock_lat),
    .o_unlock_lat (o_unlock_lat)
  );

  always #5 clk = ~clk;

  // Checker model: locks after m_lock_n clean valid cycles, unlocks after
  // m_unlock_n corrupt cycles, optionally drops lock m_drop_n clean cycles
  // after locking, and may be barred from relocking once it has dropped.
  int m_lock_n = 0, m_unlock_n = 0, m_drop_n = 0, m_relock = 1;
  int lk = 0, clean = 0, corr = 0, since = 0, dropped = 0;

  always @(negedge clk) begin
    if (o_soft_reset) begin
      lk = 0; clean = 0; corr = 0; since = 0; dropped = 0;
    end else if (o_valid && !o_corrupt) begin
      corr = 0;
      clean++;
      if (lk != 0) begin
        since++;
        if (m_drop_n != 0 && since == m_drop_n) begin
          lk = 0; dropped = 1;
        end
      end else if (m_lock_n != 0 && clean >= m_lock_n && (dropped == 0 || m_relock != 0)) begin
        lk = 1;
      end
    end else if (o_valid && o_corrupt) begin
      clean = 0;
      corr++;
      if (lk != 0 && m_unlock_n != 0 && corr >= m_unlock_n) begin
        lk = 0; dropped = 1;
      end
    end
    i_lock = (lk != 0);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int lock_n;
    int unlock_n;
    int drop_n;
    int relock;
    int len;
    int abort_at;    // busy cycle whose closing edge samples i_abort (0 = none)
    int hold_start;  // keep i_start high through the whole run and DONE
    int exp_pass;
    int exp_code;
    int exp_ll;
    int exp_ul;
    int exp_cyc;     // busy cycles including DONE
    int exp_cor;     // o_corrupt seen during the run
  } run_t;

  run_t tbl[13];

  task automatic do_run(input int idx, input run_t r);
    int    cyc;
    int    sr_cnt;
    int    cor;
    bit    done_seen;
    string p;
    p = $sformatf("run%0d", idx);
    m_lock_n = r.lock_n; m_unlock_n = r.unlock_n;
    m_drop_n = r.drop_n; m_relock = r.relock;
    @(negedge clk);
    i_start     = 1'b1;
    i_valid_len = CNT_W'(r.len);
    @(negedge clk);
    if (r.hold_start == 0) i_start = 1'b0;
    // first busy cycle: soft reset active, old results cleared
    chk({p, " srst_first"}, int'(o_soft_reset), 1);
    chk({p, " valid_first"}, int'(o_valid), 0);
    chk({p, " cleared"}, int'(o_pass) + int'(o_fail_code) + int'(o_lock_lat) + int'(o_unlock_lat), 0);
    cyc = 1; sr_cnt = 0; cor = 0; done_seen = 1'b0;
    while (!done_seen && cyc <= 200) begin
      if (o_soft_reset) sr_cnt++;
      if (o_corrupt) cor = 1;
      if (o_done) begin
        done_seen = 1'b1;
      end else begin
        i_abort = (cyc == r.abort_at);
        @(negedge clk);
        cyc++;
        if (r.abort_at != 0 && cyc == r.abort_at + 1) begin
          chk({p, " corrupt_after_abort"}, int'(o_corrupt), 0);
          chk({p, " done_after_abort"}, int'(o_done), 1);
        end
      end
    end
    i_abort = 1'b0;
    chk({p, " done_seen"}, int'(done_seen), 1);
    chk({p, " cycles"}, cyc, r.exp_cyc);
    chk({p, " pass"}, int'(o_pass), r.exp_pass);
    chk({p, " code"}, int'(o_fail_code), r.exp_code);
    chk({p, " lock_lat"}, int'(o_lock_lat), r.exp_ll);
    chk({p, " unlock_lat"}, int'(o_unlock_lat), r.exp_ul);
    chk({p, " srst_width"}, sr_cnt, 1);
    chk({p, " corrupt_seen"}, cor, r.exp_cor);
    // DONE edge has passed (with i_start possibly still high): must be IDLE
    @(posedge clk);
    #1;
    i_start = 1'b0;
    chk({p, " idle_busy"}, int'(o_busy), 0);
    chk({p, " idle_ctrl"}, int'(o_valid) + int'(o_corrupt) + int'(o_soft_reset) + int'(o_done), 0);
    chk({p, " pass_held"}, int'(o_pass), r.exp_pass);
    chk({p, " code_held"}, int'(o_fail_code), r.exp_code);
  endtask

  initial begin
    //          lk  ulk drp rl len ab  hs  pass code ll  ul  cyc cor
    tbl[0]  = '{5,  3,  0,  1, 12, 0,  0,  1,   0,   5,  3,  27, 1}; // normal
    tbl[1]  = '{0,  3,  0,  1, 12, 0,  0,  0,   1,   0,  0,  34, 0}; // no lock
    tbl[2]  = '{5,  3,  4,  1, 15, 0,  0,  0,   2,   5,  0,  11, 0}; // spurious unlock
    tbl[3]  = '{5,  0,  0,  1, 12, 0,  0,  0,   3,   5,  0,  35, 1}; // corruption ignored
    tbl[4]  = '{5,  3,  0,  0, 12, 0,  0,  0,   4,   5,  3,  54, 1}; // never relocks
    tbl[5]  = '{5,  3,  0,  1, 12, 20, 0,  0,   5,   5,  0,  21, 1}; // abort in INJECT
    tbl[6]  = '{5,  3,  0,  1, 0,  0,  1,  1,   0,   5,  3,  16, 1}; // len 0, start held
    tbl[7]  = '{32, 3,  0,  1, 2,  0,  0,  1,   0,   32, 3,  71, 1}; // lock on timeout cycle
    tbl[8]  = '{33, 3,  0,  1, 2,  0,  0,  0,   1,   0,  0,  34, 0}; // lock one cycle late
    tbl[9]  = '{5,  16, 0,  1, 3,  0,  0,  1,   0,   5,  16, 31, 1}; // unlock on timeout cycle
    tbl[10] = '{0,  3,  0,  1, 12, 33, 0,  0,   5,   0,  0,  34, 0}; // abort beats timeout
    tbl[11] = '{5,  3,  0,  1, 12, 1,  1,  0,   5,   0,  0,  2,  0}; // abort in SRST
    tbl[12] = '{5,  3,  0,  1, 12, 0,  1,  1,   0,   5,  3,  27, 1}; // normal, start held

    // reset state
    repeat (2) @(negedge clk);
    chk("reset_outputs", int'(o_soft_reset) + int'(o_valid) + int'(o_corrupt) + int'(o_busy) +
        int'(o_done) + int'(o_pass) + int'(o_fail_code) + int'(o_lock_lat) + int'(o_unlock_lat), 0);
    i_rst = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", int'(o_busy), 0);

    for (int i = 0; i < 13; i++) do_run(i, tbl[i]);

    // asynchronous reset mid-SYNC after a passing run
    m_lock_n = 0; m_unlock_n = 3; m_drop_n = 0; m_relock = 1;
    @(negedge clk);
    i_start = 1'b1; i_valid_len = CNT_W'(12);
    @(negedge clk);
    i_start = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_sync_valid", int'(o_valid), 1);
    #2 i_rst = 1'b1;
    #1;
    chk("async_rst_busy", int'(o_busy), 0);
    chk("async_rst_valid", int'(o_valid), 0);
    chk("async_rst_results", int'(o_done) + int'(o_pass) + int'(o_fail_code) +
        int'(o_lock_lat) + int'(o_soft_reset) + int'(o_corrupt), 0);
    @(negedge clk);
    i_rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("stay_idle_after_rst", int'(o_busy), 0);

    do_run(13, tbl[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
